// File: rtl/daq_pkg.sv
// Shared definitions for the AD7606 acquisition sequencer.
// Contents: sequencer state encoding, default timing/geometry values,
// the frame preamble word and common counter widths.
package daq_pkg;

  typedef enum logic [3:0] {
    IDLE,
    CONV,
    WAIT_BUSY_HI,
    WAIT_BUSY_LO,
    PRE,
    RD_LOW,
    RD_HIGH,
    NEXT,
    DONE
  } daq_state_e;

  localparam int unsigned ADCCOUNT_DEF  = 8;
  localparam int unsigned CHANCOUNT_DEF = 8;
  localparam int unsigned CONV_LO_DEF   = 4;
  localparam int unsigned RD_LO_DEF     = 2;
  localparam int unsigned RD_HI_DEF     = 2;
  localparam int unsigned BUSY_TO_DEF   = 1000;
  localparam logic [15:0] PREAMBLE_DEF  = 16'hAAAA;

  // Width of the sample-period input and of the internal cycle counters.
  localparam int unsigned RATE_W = 16;
  localparam int unsigned CNT_W  = 16;
  localparam int unsigned DB_W   = 16;

endpackage

// File: rtl/daq_seq_ctrl_if.sv
// ADC bus + FIFO write port bundle for the acquisition sequencer.
// master: sequencer side (drives CONVST, chip selects, read strobe, FIFO word/strobe).
// slave : peripheral side (AD7606 BUSY and data bus, FIFO full flag).
interface daq_seq_ctrl_if import daq_pkg::*; #(
  parameter int unsigned ADCCOUNT = ADCCOUNT_DEF
);
  logic                conv_n_o;
  logic [ADCCOUNT-1:0] cs_n_o;
  logic                rd_n_o;
  logic                busy_i;
  logic [DB_W-1:0]     db_i;
  logic [DB_W-1:0]     fifo_data_o;
  logic                fifo_wr_o;
  logic                fifo_full_i;

  modport master (
    output conv_n_o, cs_n_o, rd_n_o, fifo_data_o, fifo_wr_o,
    input  busy_i, db_i, fifo_full_i
  );

  modport slave (
    input  conv_n_o, cs_n_o, rd_n_o, fifo_data_o, fifo_wr_o,
    output busy_i, db_i, fifo_full_i
  );
endinterface

// File: rtl/daq_rate_timer.sv
// Sample-period timer.
// Ports: clk_i, reset_i (sync, active-high), en_i (enable),
//        rate_div_i (period in cycles, 0 disables), tick_o (terminal-count pulse).
// The tick is gated by en_i in the same cycle, so a tick coinciding with
// en_i falling never reaches the sequencer.
module daq_rate_timer import daq_pkg::*; (
  input  logic              clk_i,
  input  logic              reset_i,
  input  logic              en_i,
  input  logic [RATE_W-1:0] rate_div_i,
  output logic              tick_o
);

  logic [RATE_W-1:0] cnt_q;
  logic [RATE_W-1:0] cnt_d;
  logic              run;

  always_comb begin
    run    = en_i && (rate_div_i != '0);
    // >= so that lowering rate_div_i below the current count wraps at once
    tick_o = run && (cnt_q >= (rate_div_i - RATE_W'(1)));
    cnt_d  = cnt_q;
    if (!run || tick_o) begin
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + RATE_W'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/daq_seq_ctrl.sv
// AD7606 acquisition sequencer.
// On each sample tick: pulse CONVST, wait for BUSY high then low, write the
// preamble word to the FIFO, then read CHANCOUNT words from each of ADCCOUNT
// devices on the shared bus and write each to the FIFO, honouring FIFO full.
// Ports: clk_i, reset_i (sync, active-high), en_i, rate_div_i,
//        bus (ADC/FIFO bundle, master side),
//        frame_done_o / overrun_o / timeout_o one-cycle status pulses.
module daq_seq_ctrl import daq_pkg::*; #(
  parameter int unsigned ADCCOUNT  = ADCCOUNT_DEF,
  parameter int unsigned CHANCOUNT = CHANCOUNT_DEF,
  parameter int unsigned CONV_LO   = CONV_LO_DEF,
  parameter int unsigned RD_LO     = RD_LO_DEF,
  parameter int unsigned RD_HI     = RD_HI_DEF,
  parameter int unsigned BUSY_TO   = BUSY_TO_DEF,
  parameter logic [15:0] PREAMBLE  = PREAMBLE_DEF
) (
  input  logic              clk_i,
  input  logic              reset_i,
  input  logic              en_i,
  input  logic [RATE_W-1:0] rate_div_i,
  daq_seq_ctrl_if.master    bus,
  output logic              frame_done_o,
  output logic              overrun_o,
  output logic              timeout_o
);

  localparam logic [CNT_W-1:0] CONV_LAST  = CNT_W'(CONV_LO - 1);
  localparam logic [CNT_W-1:0] BUSY_LAST  = CNT_W'(BUSY_TO - 1);
  localparam logic [CNT_W-1:0] RD_LO_LAST = CNT_W'(RD_LO - 1);
  localparam logic [CNT_W-1:0] RD_HI_LAST = CNT_W'(RD_HI - 1);
  localparam logic [CNT_W-1:0] CH_LAST    = CNT_W'(CHANCOUNT - 1);
  localparam logic [2:0]       ADC_LAST   = 3'(ADCCOUNT - 1);

  daq_state_e          state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [2:0]          adc_q, adc_d;
  logic [CNT_W-1:0]    ch_q, ch_d;
  logic [DB_W-1:0]     data_q, data_d;
  logic                wr_done_q, wr_done_d;

  logic                tick;
  logic                conv_n;
  logic                cs_act;
  logic                rd_n;
  logic                fifo_wr;
  logic                wr_now;
  logic [ADCCOUNT-1:0] cs_n;

  daq_rate_timer u_timer (
    .clk_i      (clk_i),
    .reset_i    (reset_i),
    .en_i       (en_i),
    .rate_div_i (rate_div_i),
    .tick_o     (tick)
  );

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    adc_d        = adc_q;
    ch_d         = ch_q;
    data_d       = data_q;
    wr_done_d    = wr_done_q;
    conv_n       = 1'b1;
    cs_act       = 1'b0;
    rd_n         = 1'b1;
    fifo_wr      = 1'b0;
    wr_now       = 1'b0;
    frame_done_o = 1'b0;
    timeout_o    = 1'b0;
    // Any tick outside IDLE is dropped; the running frame is unaffected.
    overrun_o    = tick && (state_q != IDLE);

    unique case (state_q)
      IDLE: begin
        if (tick) begin
          state_d = CONV;
          cnt_d   = '0;
        end
      end
      CONV: begin
        conv_n = 1'b0;
        if (cnt_q == CONV_LAST) begin
          state_d = WAIT_BUSY_HI;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      WAIT_BUSY_HI: begin
        if (bus.busy_i) begin
          state_d = WAIT_BUSY_LO;
          cnt_d   = '0;
        end else if (cnt_q == BUSY_LAST) begin
          timeout_o = 1'b1;
          state_d   = IDLE;
          cnt_d     = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      WAIT_BUSY_LO: begin
        if (!bus.busy_i) begin
          state_d = PRE;
          // The preamble goes out through the same word register as samples.
          data_d  = PREAMBLE;
        end
      end
      PRE: begin
        if (!bus.fifo_full_i) begin
          fifo_wr = 1'b1;
          state_d = RD_LOW;
          adc_d   = '0;
          ch_d    = '0;
          cnt_d   = '0;
        end
      end
      RD_LOW: begin
        cs_act = 1'b1;
        rd_n   = 1'b0;
        if (cnt_q == RD_LO_LAST) begin
          data_d    = bus.db_i;
          state_d   = RD_HIGH;
          cnt_d     = '0;
          wr_done_d = 1'b0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      RD_HIGH: begin
        cs_act = 1'b1;
        // The word is written once, as soon as the FIFO can take it; the
        // high time keeps counting meanwhile and saturates at its minimum.
        wr_now  = !wr_done_q && !bus.fifo_full_i;
        fifo_wr = wr_now;
        if (wr_now) begin
          wr_done_d = 1'b1;
        end
        if (cnt_q != RD_HI_LAST) begin
          cnt_d = cnt_q + CNT_W'(1);
        end
        if ((wr_done_q || wr_now) && (cnt_q == RD_HI_LAST)) begin
          cnt_d = '0;
          if (ch_q != CH_LAST) begin
            state_d = RD_LOW;
            ch_d    = ch_q + CNT_W'(1);
          end else begin
            state_d = NEXT;
          end
        end
      end
      NEXT: begin
        if (adc_q != ADC_LAST) begin
          state_d = RD_LOW;
          adc_d   = adc_q + 3'd1;
          ch_d    = '0;
          cnt_d   = '0;
        end else begin
          state_d = DONE;
        end
      end
      DONE: begin
        frame_done_o = 1'b1;
        state_d      = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    cs_n = cs_act ? ~(ADCCOUNT'(1) << adc_q) : '1;
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      adc_q     <= '0;
      ch_q      <= '0;
      data_q    <= '0;
      wr_done_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      adc_q     <= adc_d;
      ch_q      <= ch_d;
      data_q    <= data_d;
      wr_done_q <= wr_done_d;
    end
  end

  assign bus.conv_n_o    = conv_n;
  assign bus.cs_n_o      = cs_n;
  assign bus.rd_n_o      = rd_n;
  assign bus.fifo_wr_o   = fifo_wr;
  assign bus.fifo_data_o = data_q;

endmodule

// File: tb/tb_daq_seq_ctrl.sv
// Bench for daq_seq_ctrl: AD7606 bus model plus a frame-level reference model.
module tb_daq_seq_ctrl;

  localparam int ADCS        = 8;
  localparam int CHS         = 8;
  localparam int CONVLO      = 4;
  localparam int RDHI        = 2;
  localparam int BUSYTO      = 1000;
  localparam int FRAME_WORDS = 1 + ADCS * CHS;

  logic        clk = 1'b0;
  logic        reset_i;
  logic        en_i;
  logic [15:0] rate_div_i;
  logic        frame_done_o;
  logic        overrun_o;
  logic        timeout_o;

  daq_seq_ctrl_if #(.ADCCOUNT(ADCS)) bus ();

  daq_seq_ctrl #(
    .ADCCOUNT (ADCS),
    .CHANCOUNT(CHS),
    .CONV_LO  (CONVLO),
    .RD_LO    (2),
    .RD_HI    (RDHI),
    .BUSY_TO  (BUSYTO),
    .PREAMBLE (16'hAAAA)
  ) dut (
    .clk_i       (clk),
    .reset_i     (reset_i),
    .en_i        (en_i),
    .rate_div_i  (rate_div_i),
    .bus         (bus),
    .frame_done_o(frame_done_o),
    .overrun_o   (overrun_o),
    .timeout_o   (timeout_o)
  );

  always #5 clk = ~clk;

  int n_pass = 0;
  int n_chk  = 0;

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    n_chk++;
    if (act !== exp) $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    else n_pass++;
  endtask

  // Shared bookkeeping
  int          cyc = 0;
  int          writes_total = 0, frames_done = 0, timeouts = 0, overruns = 0;
  int          conv_falls = 0, fall_cyc = 0, to_cyc = 0;
  logic [3:0]  conv_tag = 4'd0;
  logic [15:0] wlog [0:4095];
  int          done_cyc [0:31];
  int          bch [0:ADCS-1];
  int          bfm_mode = 0;   // 0 = normal BUSY, 1 = BUSY stuck low

  // Reference model state
  int s_en = 0, active = 0, conv_rem = 0, waiting = 0, wait_cnt = 0, done_cd = 0, word_idx = 0;

  // Word k of a frame: preamble, then device a channel c as presented by the bus model.
  function automatic logic [15:0] exp_word(int k);
    if (k == 0) return 16'hAAAA;
    return {4'hD, conv_tag, 4'((k - 1) / CHS), 4'((k - 1) % CHS)};
  endfunction

  // ---------------- compare process ----------------
  always @(negedge clk) begin : cmp
    logic mtick;
    int   act0;
    int   set_done;
    cyc++;
    mtick = 1'b0;
    if (en_i && rate_div_i != 16'd0) mtick = (((s_en + 1) % int'(rate_div_i)) == 0);
    act0 = active;
    set_done = 0;
    if (reset_i) begin
      active = 0; conv_rem = 0; waiting = 0; wait_cnt = 0; done_cd = 0; word_idx = 0;
    end else begin
      chk("conv_n", bus.conv_n_o, conv_rem == 0);
      chk("overrun", overrun_o, mtick && act0 != 0);
      chk("timeout", timeout_o, waiting != 0 && !bus.busy_i && wait_cnt == BUSYTO - 1);
      chk("frame_done", frame_done_o, done_cd == 1);
      chk("cs_onehot", $countones(~bus.cs_n_o) <= 1, 1);
      if (bus.fifo_wr_o === 1'b1) begin
        chk("wr_active", act0 != 0, 1);
        chk("wr_not_full", bus.fifo_full_i, 0);
        chk("wr_data", bus.fifo_data_o, exp_word(word_idx));
        if (writes_total < 4096) wlog[writes_total] = bus.fifo_data_o;
        writes_total++;
        word_idx++;
        if (word_idx == FRAME_WORDS) begin
          word_idx = 0;
          set_done = 1;
        end
      end
      if (frame_done_o === 1'b1) begin
        if (frames_done < 32) done_cyc[frames_done] = cyc;
        frames_done++;
      end
      if (timeout_o === 1'b1) begin timeouts++; to_cyc = cyc; end
      if (overrun_o === 1'b1) overruns++;

      if (done_cd == 1) active = 0;
      if (done_cd > 0) done_cd--;
      if (set_done != 0) done_cd = RDHI + 1;
      if (waiting != 0) begin
        if (bus.busy_i) waiting = 0;
        else if (wait_cnt == BUSYTO - 1) begin waiting = 0; active = 0; end
        else wait_cnt++;
      end
      if (conv_rem > 0) begin
        conv_rem--;
        if (conv_rem == 0) begin waiting = 1; wait_cnt = 0; end
      end
      if (mtick && act0 == 0) begin active = 1; conv_rem = CONVLO; end
    end
    if (reset_i || !en_i || rate_div_i == 16'd0) s_en = 0;
    else s_en++;
  end

  // ---------------- AD7606 bus model ----------------
  initial begin : bfm
    int   since;
    int   in_conv;
    logic prev_conv;
    logic prev_rd;
    int   prev_sel;
    int   sel;
    bus.busy_i = 1'b0;
    bus.db_i   = 16'h0000;
    since = 0; in_conv = 0; prev_conv = 1'b1; prev_rd = 1'b1; prev_sel = -1;
    for (int a = 0; a < ADCS; a++) bch[a] = 0;
    forever begin
      @(posedge clk); #1;
      if (prev_conv === 1'b1 && bus.conv_n_o === 1'b0) begin
        conv_falls++;
        conv_tag = conv_tag + 4'd1;
        fall_cyc = cyc + 1;
        since = 0; in_conv = 1;
        for (int a = 0; a < ADCS; a++) bch[a] = 0;
      end else if (in_conv != 0) begin
        since++;
      end
      if (in_conv != 0 && since >= 205) in_conv = 0;
      bus.busy_i = (bfm_mode == 0) && (in_conv != 0) && since >= 5 && since < 205;
      sel = -1;
      for (int a = 0; a < ADCS; a++) if (bus.cs_n_o[a] === 1'b0) sel = a;
      if (prev_rd === 1'b0 && bus.rd_n_o === 1'b1 && prev_sel >= 0) bch[prev_sel]++;
      if (bus.rd_n_o === 1'b0 && sel >= 0) bus.db_i = {4'hD, conv_tag, 4'(sel), 4'(bch[sel])};
      else bus.db_i = 16'h0000;
      prev_conv = bus.conv_n_o;
      prev_rd   = bus.rd_n_o;
      prev_sel  = sel;
    end
  end

  // ---------------- stimulus ----------------
  task automatic step(int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic check_reset_vals(string tag);
    @(negedge clk);
    chk({tag, "_conv_n"}, bus.conv_n_o, 1);
    chk({tag, "_cs_n"}, bus.cs_n_o, 8'hFF);
    chk({tag, "_rd_n"}, bus.rd_n_o, 1);
    chk({tag, "_fifo_wr"}, bus.fifo_wr_o, 0);
    chk({tag, "_fifo_data"}, bus.fifo_data_o, 16'h0000);
    chk({tag, "_pulses"}, {frame_done_o, overrun_o, timeout_o}, 3'b000);
  endtask

  task automatic do_reset(string tag);
    en_i = 1'b0;
    reset_i = 1'b1;
    step(1);
    reset_i = 1'b0;
    check_reset_vals(tag);
  endtask

  task automatic wait_frames(int target, int budget, string name);
    int i = 0;
    while (frames_done < target && i < budget) begin step(1); i++; end
    chk(name, frames_done, target);
  endtask

  task automatic wait_read(int adc, int ch, int budget, string name);
    int i = 0;
    while (!(bus.cs_n_o[adc] === 1'b0 && bus.rd_n_o === 1'b0 && bch[adc] == ch) && i < budget) begin
      step(1); i++;
    end
    chk(name, i < budget, 1);
  endtask

  task automatic wait_idle(int budget, string name);
    int i = 0;
    while (active != 0 && i < budget) begin step(1); i++; end
    chk(name, active, 0);
  endtask

  initial begin : stim
    int w0, f0, c0, t0, rd_low_cnt;
    reset_i = 1'b1; en_i = 1'b0; rate_div_i = 16'd0; bus.fifo_full_i = 1'b0;
    step(3);
    reset_i = 1'b0;
    check_reset_vals("init");

    // Normal acquisition, two frames
    rate_div_i = 16'd2000; en_i = 1'b1;
    wait_frames(1, 2600, "t1_frame1");
    wait_frames(2, 2100, "t1_frame2");
    chk("t1_writes", writes_total, 2 * FRAME_WORDS);
    chk("t1_w0", wlog[0], 16'hAAAA);
    chk("t1_w1", wlog[1], 16'hD100);
    chk("t1_w64", wlog[64], 16'hD177);
    chk("t1_w65", wlog[65], 16'hAAAA);
    chk("t1_w66", wlog[66], 16'hD200);
    chk("t1_period", done_cyc[1] - done_cyc[0], 2000);

    // FIFO full during adc3 ch5
    do_reset("t2_rst");
    w0 = writes_total; f0 = frames_done;
    rate_div_i = 16'd2000; en_i = 1'b1;
    wait_read(3, 5, 2600, "t2_reach_a3c5");
    bus.fifo_full_i = 1'b1;
    rd_low_cnt = 0;
    for (int i = 0; i < 50; i++) begin
      step(1);
      if (i >= 2 && bus.rd_n_o !== 1'b1) rd_low_cnt++;
    end
    chk("t2_rd_held_high", rd_low_cnt, 0);
    bus.fifo_full_i = 1'b0;
    wait_frames(f0 + 1, 2000, "t2_frame");
    chk("t2_writes", writes_total - w0, FRAME_WORDS);
    chk("t2_a3c5", wlog[w0 + 30][7:0], 8'h35);
    chk("t2_a3c6", wlog[w0 + 31][7:0], 8'h36);

    // BUSY stuck low
    do_reset("t3_rst");
    bfm_mode = 1;
    w0 = writes_total; t0 = timeouts;
    rate_div_i = 16'd1500; en_i = 1'b1;
    begin
      int i = 0;
      while (timeouts == t0 && i < 3000) begin step(1); i++; end
    end
    chk("t3_timeout_seen", timeouts, t0 + 1);
    chk("t3_timeout_delay", to_cyc - fall_cyc, CONVLO + BUSYTO - 1);
    chk("t3_no_writes", writes_total - w0, 0);
    c0 = conv_falls;
    begin
      int i = 0;
      while (conv_falls == c0 && i < 1000) begin step(1); i++; end
    end
    chk("t3_restart_conv", conv_falls, c0 + 1);
    en_i = 1'b0;
    wait_idle(1200, "t3_idle");
    bfm_mode = 0;

    // Sample period shorter than a frame
    do_reset("t4_rst");
    w0 = writes_total; f0 = frames_done; t0 = overruns;
    rate_div_i = 16'd100; en_i = 1'b1;
    wait_frames(f0 + 2, 1600, "t4_frames");
    chk("t4_overruns", overruns - t0 >= 3, 1);
    chk("t4_writes", writes_total - w0, 2 * FRAME_WORDS);
    en_i = 1'b0;
    wait_idle(1000, "t4_idle");

    // Reset during adc5 ch2
    do_reset("t5_rst");
    rate_div_i = 16'd2000; en_i = 1'b1;
    wait_read(5, 2, 2600, "t5_reach_a5c2");
    reset_i = 1'b1;
    step(1);
    reset_i = 1'b0;
    check_reset_vals("t5_mid");
    w0 = writes_total; f0 = frames_done;
    step(20);
    chk("t5_no_writes_after_rst", writes_total - w0, 0);
    wait_frames(f0 + 1, 2600, "t5_next_frame");
    chk("t5_first_word", wlog[w0], 16'hAAAA);
    chk("t5_writes", writes_total - w0, FRAME_WORDS);

    // Enable dropped mid-frame
    do_reset("t6_rst");
    f0 = frames_done; w0 = writes_total;
    rate_div_i = 16'd2000; en_i = 1'b1;
    wait_read(1, 0, 2600, "t6_reach_a1");
    en_i = 1'b0;
    c0 = conv_falls;
    wait_frames(f0 + 1, 600, "t6_frame_completes");
    chk("t6_writes", writes_total - w0, FRAME_WORDS);
    step(3000);
    chk("t6_no_conv", conv_falls, c0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
